// File: rtl/dmx_spi_pkg.sv
// Shared types and constants for the DMX SPI receive path.
package dmx_spi_pkg;

  // Bits in one {param, value} frame; control_FSM relies on the same figure.
  localparam int unsigned FRAME_BITS = 16;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} spi_rx_state_t;

endpackage

// File: rtl/spi_frame_rx_sync_edge.sv
// Multi-flop synchroniser with registered-edge detection on the synchronised level.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Shift the async input through the synchroniser and keep one delayed copy for edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI frame receiver: synchronises sck/sdi/load, assembles a {param, value} frame,
// validates its length and holds it for a valid/ready consumer.
module spi_frame_rx
  import dmx_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BYTE_W      = FRAME_BITS / 2
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              sck,
  input  logic              sdi,
  input  logic              load,
  input  logic              frame_ready,
  output logic              frame_valid,
  output logic [BYTE_W-1:0] param_out,
  output logic [BYTE_W-1:0] value_out,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned NBITS = 2 * BYTE_W;
  localparam int unsigned CW    = $clog2(NBITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(NBITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(NBITS + 1);

  spi_rx_state_t    state, state_nxt;
  logic [NBITS-1:0] shreg;
  logic [CW-1:0]    cnt;

  logic sck_rise, load_rise, load_fall, sdi_s, sdi_a;
  logic clr, shift_en, capture, drop, bad;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck (
    .clk(sysclk), .rst(reset), .din(sck), .level(), .rise(sck_rise), .fall()
  );

  // load synchroniser resets high: a load already high at reset release gives no
  // rising edge, so a frame in progress is never joined midway.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_load (
    .clk(sysclk), .rst(reset), .din(load), .level(), .rise(load_rise), .fall(load_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sdi (
    .clk(sysclk), .rst(reset), .din(sdi), .level(sdi_s), .rise(), .fall()
  );

  // State register plus sdi alignment flop matching the sck edge detector delay.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sdi_a <= 1'b0;
    end else begin
      state <= state_nxt;
      sdi_a <= sdi_s;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    shift_en  = 1'b0;
    capture   = 1'b0;
    drop      = 1'b0;
    bad       = 1'b0;
    case (state)
      IDLE: begin
        if (load_rise) begin
          clr       = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (load_fall) state_nxt = CHECK;
        else if (sck_rise) shift_en = 1'b1;
      end
      CHECK: begin
        state_nxt = IDLE;
        if (cnt == CNT_FULL) begin
          if (!frame_valid || frame_ready) capture = 1'b1;
          else drop = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and saturating bit counter.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clr) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[NBITS-2:0], sdi_a};
      cnt   <= (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
    end
  end

  // Holding register with valid/ready handshake and error/overrun pulses.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      frame_valid <= 1'b0;
      param_out   <= '0;
      value_out   <= '0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_err <= bad;
      overrun   <= drop;
      if (capture) begin
        frame_valid <= 1'b1;
        param_out   <= shreg[NBITS-1:BYTE_W];
        value_out   <= shreg[BYTE_W-1:0];
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Scoreboard bench for spi_frame_rx: stimulus pushes expected frames, a monitor pops them.
module tb_spi_frame_rx;
  import dmx_spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0, sdi = 1'b0, load = 1'b0, frame_ready = 1'b0;
  logic       frame_valid, frame_err, overrun;
  logic [7:0] param_out, value_out;

  int tests = 0, fails = 0;
  int err_seen = 0, ovr_seen = 0, exp_err = 0, exp_ovr = 0;
  logic [15:0] expq[$];
  bit rand_ready = 1'b0;

  always #5 clk = ~clk;

  spi_frame_rx #(.SYNC_STAGES(2), .BYTE_W(8)) dut (
    .sysclk(clk), .reset(rst), .sck(sck), .sdi(sdi), .load(load),
    .frame_ready(frame_ready), .frame_valid(frame_valid),
    .param_out(param_out), .value_out(value_out),
    .frame_err(frame_err), .overrun(overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sdi = b;
    repeat (4) cyc();
    sck = 1'b1;
    repeat (4) cyc();
    sck = 1'b0;
  endtask

  // Frame of nbits taken from the low bits of data, MSB first.
  task automatic send_frame(input int nbits, input logic [31:0] data);
    load = 1'b1;
    repeat (4) cyc();
    for (int i = nbits - 1; i >= 0; i--) send_bit(data[i]);
    repeat (4) cyc();
    load = 1'b0;
    repeat (10) cyc();
  endtask

  // Reference rule: only a frame of exactly 16 bits is a good frame.
  task automatic model_frame(input int nbits, input logic [31:0] data);
    if (nbits == 16) expq.push_back(data[15:0]);
    else exp_err++;
  endtask

  // Random consumer readiness during the random phase.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) frame_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: counts pulses, checks hold stability and pops the scoreboard on transfers.
  initial begin
    logic       prev_hold;
    logic [7:0] prev_p, prev_v;
    logic [15:0] e;
    prev_hold = 1'b0;
    prev_p = '0;
    prev_v = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", {31'd0, frame_valid}, 32'd1);
          chk("hold_param", {24'd0, param_out}, {24'd0, prev_p});
          chk("hold_value", {24'd0, value_out}, {24'd0, prev_v});
        end
        if (frame_err) err_seen++;
        if (overrun) ovr_seen++;
        if (frame_valid && frame_ready) begin
          if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame: got %0h/%0h expected none", param_out, value_out);
          end else begin
            e = expq.pop_front();
            chk("frame_param", {24'd0, param_out}, {24'd0, e[15:8]});
            chk("frame_value", {24'd0, value_out}, {24'd0, e[7:0]});
          end
        end
        prev_hold = frame_valid && !frame_ready;
        prev_p = param_out;
        prev_v = value_out;
      end
    end
  end

  initial begin
    int n;
    logic [31:0] d;
    bit hit;

    // Reset state
    repeat (3) cyc();
    chk("rst_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_param", {24'd0, param_out}, 32'd0);
    chk("rst_value", {24'd0, value_out}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    repeat (4) cyc();

    // Basic frame with consumer ready
    frame_ready = 1'b1;
    model_frame(16, 32'h12AB);
    send_frame(16, 32'h12AB);
    chk("basic_drained", expq.size(), 32'd0);
    chk("basic_err", err_seen, exp_err);
    chk("basic_ovr", ovr_seen, 32'd0);

    // Short then long frame
    model_frame(15, 32'h1234);
    send_frame(15, 32'h1234);
    model_frame(17, 32'h1ABCD);
    send_frame(17, 32'h1ABCD);
    chk("len_err_count", err_seen, exp_err);
    chk("len_no_frame", expq.size(), 32'd0);

    // Overrun with consumer stalled
    frame_ready = 1'b0;
    model_frame(16, 32'h0102);
    send_frame(16, 32'h0102);
    send_frame(16, 32'h0304);
    exp_ovr++;
    chk("ovr_count", ovr_seen, exp_ovr);
    chk("ovr_valid", {31'd0, frame_valid}, 32'd1);
    chk("ovr_param", {24'd0, param_out}, 32'h01);
    chk("ovr_value", {24'd0, value_out}, 32'h02);
    frame_ready = 1'b1;
    cyc();
    cyc();
    chk("ovr_consumed_valid", {31'd0, frame_valid}, 32'd0);
    chk("ovr_drained", expq.size(), 32'd0);

    // Back-to-back with consume in the capture cycle of the second
    frame_ready = 1'b0;
    model_frame(16, 32'h1122);
    send_frame(16, 32'h1122);
    model_frame(16, 32'h3344);
    fork
      send_frame(16, 32'h3344);
      begin
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
          cyc();
          if (dut.state == CHECK) hit = 1'b1;
        end
        if (!hit) begin
          tests++;
          fails++;
          $display("FAIL b2b_timeout: got no CHECK expected CHECK within 400 cycles");
        end
        frame_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_valid", {31'd0, frame_valid}, 32'd1);
        chk("b2b_param", {24'd0, param_out}, 32'h33);
        chk("b2b_value", {24'd0, value_out}, 32'h44);
      end
    join
    chk("b2b_drained", expq.size(), 32'd0);
    chk("b2b_ovr", ovr_seen, exp_ovr);

    // Reset after bit 9 of a frame
    load = 1'b1;
    repeat (4) cyc();
    for (int i = 0; i < 9; i++) send_bit(1'($urandom_range(0, 1)));
    rst = 1'b1;
    repeat (3) cyc();
    load = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    repeat (8) cyc();
    model_frame(16, 32'h55AA);
    send_frame(16, 32'h55AA);
    chk("rstmid_err", err_seen, exp_err);
    chk("rstmid_drained", expq.size(), 32'd0);

    // Load held high across reset release
    load = 1'b1;
    cyc();
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    repeat (4) cyc();
    for (int i = 15; i >= 0; i--) send_bit(d[0] ^ 1'(i % 2));
    repeat (4) cyc();
    load = 1'b0;
    repeat (10) cyc();
    chk("joined_ignored", expq.size() + err_seen, exp_err);
    model_frame(16, 32'h5AC3);
    send_frame(16, 32'h5AC3);
    chk("after_join_drained", expq.size(), 32'd0);

    // Random frames with a randomly stalling consumer
    rand_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      n = ($urandom_range(0, 2) != 0) ? 16 : int'($urandom_range(14, 18));
      d = $urandom;
      model_frame(n, d);
      send_frame(n, d);
    end
    rand_ready = 1'b0;
    frame_ready = 1'b1;
    repeat (10) cyc();
    chk("rand_drained", expq.size(), 32'd0);
    chk("rand_err", err_seen, exp_err);
    chk("rand_ovr", ovr_seen, exp_ovr);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "timeout");
  end

endmodule
